vga_fb_arbiter: RTL
===================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter FB_W, default 320, framebuffer width in words; each word covers one 2x2 block of 640x480 pixels.
REQ-002 Parameter FB_H, default 240, framebuffer height in words.
REQ-003 Parameter AW, default 17, address width; DW, default 12, data width (4:4:4 RGB).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pix_strb_i  input  1  pixel strobe from the timing generator, high every second clk.
REQ-007 active_i  input  1  timing generator in visible region.
REQ-008 x_i  input  10  current pixel column; y_i  input  9  current pixel row.
REQ-009 wr_valid_i  input  1, wr_addr_i  input  AW, wr_data_i  input  DW: host write request.
REQ-010 wr_ready_o  output  1  host write accepted this cycle.
REQ-011 clr_i  input  1  start-clear pulse; clr_data_i  input  DW  clear colour.
REQ-012 clr_busy_o  output  1  clear sweep in progress.
REQ-013 mem_en_o  output  1, mem_we_o  output  1, mem_addr_o  output  AW, mem_wdata_o  output  DW: single-port RAM port.
REQ-014 mem_rdata_i  input  DW  RAM read data, valid one clk after the read cycle.
REQ-015 pix_o  output  DW  registered pixel colour to the DAC pins.
REQ-016 stall_cnt_o  output  16  host stall count (see Configuration).

Function
REQ-017 Display fetch SHALL own the RAM in every cycle where pix_strb_i & active_i: mem_en=1, mem_we=0, mem_addr = y_i[8:1]*FB_W + x_i[9:1].
REQ-018 In all other cycles the RAM SHALL be granted to the clear engine if clr_busy_o, else to the host if wr_valid_i.
REQ-019 Host handshake: wr_ready_o = wr_valid_i & ~fetch_slot & ~clr_busy_o; the write is issued in the same cycle; wr_addr_i/wr_data_i are held by the host until ready.
REQ-020 Host writes with wr_addr_i >= FB_W*FB_H SHALL be accepted (ready=1) but SHALL NOT assert mem_en_o.
REQ-021 pix_o SHALL latch mem_rdata_i one clk after a fetch cycle; it SHALL be 0 one clk after any strobe cycle with active_i=0, and SHALL otherwise hold its value.
REQ-022 Clear FSM states: IDLE, CLEAR. In IDLE, clr_i=1 -> CLEAR with clr_addr=0 and clr_data_i latched.
REQ-023 In CLEAR, each non-fetch cycle SHALL write latched colour to clr_addr and increment clr_addr; the write at clr_addr = FB_W*FB_H-1 SHALL return the FSM to IDLE on the next edge.
REQ-024 clr_i asserted while in CLEAR SHALL be ignored.
REQ-025 clr_busy_o = (state == CLEAR), registered.
REQ-026 Simultaneous clr_i and wr_valid_i in IDLE: the host write in that cycle SHALL complete; the clear SHALL start on the next edge.

Reset
REQ-027 Reset SHALL force state=IDLE, clr_addr=0, pix_o=0, stall counter=0; outputs derived from this state SHALL settle to clr_busy_o=0 and mem_en_o=0 in a no-request, no-fetch cycle.
REQ-028 Reset mid-clear SHALL abandon the sweep; no resumption after release.

Configuration
REQ-029 With FB_STALL_CNT_EN defined: stall_cnt_o SHALL count cycles with wr_valid_i & ~wr_ready_o, saturating at 16'hFFFF.
REQ-030 Without FB_STALL_CNT_EN: stall_cnt_o SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-031 Shared package vga_fb_pkg SHALL hold FB_W/FB_H/AW/DW defaults, the FSM state encoding and the pixel-to-address function.
REQ-032 A sub-module vga_fb_clear SHALL hold the clear FSM and address counter; arbitration muxing stays in the top.

Verification
REQ-033 Fetch: active_i=1, pix_strb_i=1, x=10, y=5 -> mem_addr_o=2*320+5=645, mem_we_o=0; next clk, mem_rdata_i=12'hF00 -> following clk pix_o=12'hF00.
REQ-034 Collision: wr_valid_i held from a fetch cycle -> wr_ready_o=0 that cycle, 1 the next cycle, with mem_we_o=1 and mem_addr_o=wr_addr_i.
REQ-035 Clear: clr_i pulse, clr_data_i=12'h0F0, active_i=0 -> 76800 consecutive writes from address 0 to 76799, then clr_busy_o=0; host held off throughout.
REQ-036 Out-of-range write: wr_addr_i=76800 -> wr_ready_o=1, mem_en_o=0.
REQ-037 Reset at clr_addr=100 -> clr_busy_o=0 and pix_o=0 immediately; no writes after release.
REQ-038 With FB_STALL_CNT_EN: 5 blocked wr_valid_i cycles -> stall_cnt_o=5; without the macro -> stall_cnt_o=0.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared defaults, clear-FSM encoding and pixel-to-word address mapping for
// the VGA framebuffer arbiter.
package vga_fb_pkg;

    localparam int FB_W_DEF = 320;
    localparam int FB_H_DEF = 240;
    localparam int AW_DEF   = 17;
    localparam int DW_DEF   = 12;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;

    // Each framebuffer word covers a 2x2 pixel block, so callers pass the
    // already-halved column and row.
    function automatic logic [31:0] pix_to_addr(input logic [8:0] col_half,
                                                input logic [7:0] row_half,
                                                input int         fb_w);
        return 32'(row_half) * 32'(fb_w) + 32'(col_half);
    endfunction

endpackage

// File: rtl/vga_fb_clear.sv
// Clear engine: sweeps the whole framebuffer with one colour, yielding every
// cycle that belongs to display fetch.
module vga_fb_clear
    import vga_fb_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = FB_W_DEF * FB_H_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          fetch_slot,
    input  logic [DW-1:0] color_in,
    output logic          busy,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] color
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    clr_state_e state;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLR_IDLE;
            addr  <= '0;
            color <= '0;
        end else begin
            case (state)
                CLR_IDLE: begin
                    if (start) begin
                        state <= CLR_CLEAR;
                        addr  <= '0;
                        color <= color_in;
                    end
                end
                CLR_CLEAR: begin
                    if (!fetch_slot) begin
                        if (addr == LAST) begin
                            state <= CLR_IDLE;
                            addr  <= '0;
                        end else begin
                            addr <= addr + AW'(1);
                        end
                    end
                end
                default: state <= CLR_IDLE;
            endcase
        end
    end

    assign busy = (state == CLR_CLEAR);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display fetch > clear sweep > host write.
// Optional host stall counter enabled by defining FB_STALL_CNT_EN.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int FB_W = FB_W_DEF,
    parameter int FB_H = FB_H_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_strb_i,
    input  logic          active_i,
    input  logic [9:0]    x_i,
    input  logic [8:0]    y_i,
    input  logic          wr_valid_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          wr_ready_o,
    input  logic          clr_i,
    input  logic [DW-1:0] clr_data_i,
    output logic          clr_busy_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [DW-1:0] pix_o,
    output logic [15:0]   stall_cnt_o
);

    localparam int          DEPTH   = FB_W * FB_H;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    logic          fetch_slot;
    logic          host_in_range;
    logic [AW-1:0] fetch_addr;
    logic [AW-1:0] clr_addr;
    logic [DW-1:0] clr_color;
    logic          fetch_d;
    logic          blank_d;
    logic          unused_ok;

    assign fetch_slot    = pix_strb_i & active_i;
    assign fetch_addr    = AW'(pix_to_addr(x_i[9:1], y_i[8:1], FB_W));
    assign host_in_range = 32'(wr_addr_i) < DEPTH_U;
    assign wr_ready_o    = wr_valid_i & ~fetch_slot & ~clr_busy_o;
    assign unused_ok     = &{1'b0, x_i[0], y_i[0]};

    vga_fb_clear #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_clear (
        .clk        (clk),
        .reset      (reset),
        .start      (clr_i),
        .fetch_slot (fetch_slot),
        .color_in   (clr_data_i),
        .busy       (clr_busy_o),
        .addr       (clr_addr),
        .color      (clr_color)
    );

    // NOTE: every output gets a default first so no path through the
    // priority chain leaves a signal unassigned and infers a latch.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (fetch_slot) begin
            mem_en_o   = 1'b1;
            mem_addr_o = fetch_addr;
        end else if (clr_busy_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = clr_addr;
            mem_wdata_o = clr_color;
        end else if (wr_valid_i && host_in_range) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = wr_addr_i;
            mem_wdata_o = wr_data_i;
        end
    end

    // Read data arrives one clk after the fetch, so the strobe decision is
    // delayed by one stage to line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_d <= 1'b0;
            blank_d <= 1'b0;
            pix_o   <= '0;
        end else begin
            fetch_d <= fetch_slot;
            blank_d <= pix_strb_i & ~active_i;
            if (fetch_d) begin
                pix_o <= mem_rdata_i;
            end else if (blank_d) begin
                pix_o <= '0;
            end
        end
    end

`ifdef FB_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (wr_valid_i && !wr_ready_o && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
